mod_add_pipe: RTL and testbench

Pipelined streaming modular adder: computes c = (a + b) mod q on 23-bit coefficients, with valid/ready handshakes on both sides. It complements the combinational modular subtractor and supplies the addition half of NTT butterflies and polynomial additions in the arithmetic datapath. It has two register stages and full backpressure support, and it sits between the coefficient memory read port and the butterfly/writeback logic.

---
 rtl/mod_arith_pkg.sv | 11 +
 rtl/mod_add_reduce.sv | 20 ++
 rtl/mod_add_pipe.sv | 68 ++++++
 tb/tb_mod_add_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared widths, types and modulus for the modular arithmetic datapath
package mod_arith_pkg;

    localparam int COEFF_W = 23;

    typedef logic [COEFF_W-1:0] coeff_t;
    typedef logic [COEFF_W:0]   coeff_ext_t;

    localparam coeff_t Q_DILITHIUM = 23'h7FE001;

endpackage

// File: rtl/mod_add_reduce.sv
// rtl/mod_add_reduce.sv - single conditional subtraction of q from a W+1-bit sum
module mod_add_reduce
    import mod_arith_pkg::*;
(
    input  coeff_ext_t s,
    input  coeff_t     q,
    output coeff_t     c
);

    coeff_ext_t q_ext;
    coeff_ext_t diff;

    // One subtraction only: operands >= q are not fully reduced, the result is just truncated
    always_comb begin
        q_ext = {1'b0, q};
        diff  = s - q_ext;
        c     = (s >= q_ext) ? diff[COEFF_W-1:0] : s[COEFF_W-1:0];
    end

endmodule

// File: rtl/mod_add_pipe.sv
// rtl/mod_add_pipe.sv - two-stage streaming modular adder with valid/ready backpressure
module mod_add_pipe
    import mod_arith_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [COEFF_W-1:0] a_i,
    input  logic [COEFF_W-1:0] b_i,
    input  logic [COEFF_W-1:0] q_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [COEFF_W-1:0] c_o
);

    logic       s1_v_q;
    coeff_ext_t s1_sum_q;
    coeff_t     s1_q_q;
    coeff_ext_t s1_sum_d;

    logic       s2_v_q;
    coeff_t     s2_c_q;
    coeff_t     s2_c_d;

    logic       en1;
    logic       en2;

    // Stage enables: a stage advances when it is empty or the stage after it is moving,
    // which collapses bubbles and lets a full pipe accept and drain in the same cycle
    always_comb begin
        en2      = !s2_v_q || ready_i;
        en1      = !s1_v_q || en2;
        ready_o  = en1 && !rst_i;
        s1_sum_d = {1'b0, a_i} + {1'b0, b_i};
    end

    mod_add_reduce u_reduce (
        .s (s1_sum_q),
        .q (s1_q_q),
        .c (s2_c_d)
    );

    // Stage registers; reset discards everything in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q   <= 1'b0;
            s1_sum_q <= '0;
            s1_q_q   <= '0;
            s2_v_q   <= 1'b0;
            s2_c_q   <= '0;
        end else begin
            if (en1) begin
                s1_v_q   <= valid_i;
                s1_sum_q <= s1_sum_d;
                s1_q_q   <= q_i;
            end
            if (en2) begin
                s2_v_q <= s1_v_q;
                s2_c_q <= s2_c_d;
            end
        end
    end

    assign valid_o = s2_v_q;
    assign c_o     = s2_c_q;

endmodule

// File: tb/tb_mod_add_pipe.sv
// tb/tb_mod_add_pipe.sv - randomized scoreboard bench for mod_add_pipe
module tb_mod_add_pipe;
    import mod_arith_pkg::*;

    localparam logic [22:0] Q = Q_DILITHIUM;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [22:0] a_i;
    logic [22:0] b_i;
    logic [22:0] q_i;
    logic        valid_o;
    logic        ready_i;
    logic [22:0] c_o;

    mod_add_pipe dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .q_i     (q_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    logic [22:0] exp_q[$];
    int          stamp_q[$];
    logic        rst_prev = 1'b0;
    logic        stalled  = 1'b0;
    logic [22:0] stall_c  = '0;
    logic        tp_win   = 1'b0;
    int          tp_cnt   = 0;
    int          out_cnt  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] ref_add(input longint a, input longint b, input longint q);
        longint r;
        r = a + b;
        if (r >= q) r = r - q;
        return r[22:0];
    endfunction

    always @(posedge clk) edges++;

    // Scoreboard: ordered queue of expected results stamped with the edge they were accepted on
    always @(negedge clk) begin
        logic exp_v;
        if (rst_prev) begin
            chk("rst_valid_o", valid_o, 0);
            chk("rst_c_o", c_o, 0);
        end
        if (rst_i) begin
            chk("rst_ready_o", ready_o, 0);
            exp_q.delete();
            stamp_q.delete();
            stalled  = 1'b0;
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            exp_v = 1'b0;
            if (exp_q.size() > 0) exp_v = (stamp_q[0] <= edges - 1);
            chk("valid_o", valid_o, exp_v);
            if (valid_o && exp_v) chk("c_o", c_o, exp_q[0]);
            chk("ready_o", ready_o, (exp_q.size() < 2) || ready_i);
            if (stalled) begin
                chk("stall_valid_o", valid_o, 1);
                chk("stall_c_o", c_o, stall_c);
            end
            stalled = valid_o && !ready_i;
            stall_c = c_o;
            if (valid_o && ready_i && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
                out_cnt++;
                if (tp_win) tp_cnt++;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(ref_add(a_i, b_i, q_i));
                stamp_q.push_back(edges + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string nm, input logic [22:0] a, input logic [22:0] b,
                            input logic [22:0] expc);
        chk({nm, "_model"}, ref_add(a, b, Q), expc);
        ready_i = 1'b1;
        valid_i = 1'b1;
        a_i = a;
        b_i = b;
        q_i = Q;
        tick();
        valid_i = 1'b0;
        tick();
        @(negedge clk);
        chk({nm, "_latency_valid"}, valid_o, 1);
        chk({nm, "_c"}, c_o, expc);
        tick();
        tick();
    endtask

    initial begin
        int sent;
        int base_out;
        logic acc;
        logic [22:0] rq;

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        a_i = '0; b_i = '0; q_i = Q;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();

        directed("basic", 23'h000123, 23'h000456, 23'h000579);
        directed("sum_eq_q", 23'h7FE000, 23'h000001, 23'h000000);
        directed("wrap", 23'h400000, 23'h3FF000, 23'h000FFF);
        directed("max", 23'h7FE000, 23'h7FE000, 23'h7FDFFF);
        directed("q_minus_1", 23'h7FE000, 23'h000000, 23'h7FE000);
        directed("zero", 23'h000000, 23'h000000, 23'h000000);

        // Backpressure: 5 operands, downstream stalled on cycles 3..8
        base_out = out_cnt;
        sent = 0;
        for (int c = 0; c < 24; c++) begin
            ready_i = !(c >= 3 && c <= 8);
            valid_i = (sent < 5);
            a_i = 23'h100000 + 23'(sent * 23'h111);
            b_i = 23'h6F0000 - 23'(sent * 23'h1001);
            q_i = Q;
            @(negedge clk);
            acc = valid_i && ready_o;
            tick();
            if (acc) sent++;
        end
        valid_i = 1'b0;
        chk("bp_sent", sent, 5);
        chk("bp_results", out_cnt - base_out, 5);

        // Reset with two transactions in flight
        ready_i = 1'b0;
        sent = 0;
        for (int c = 0; c < 6 && sent < 2; c++) begin
            valid_i = 1'b1;
            a_i = 23'h0ABCDE; b_i = 23'h012345;
            @(negedge clk);
            acc = valid_i && ready_o;
            tick();
            if (acc) sent++;
        end
        valid_i = 1'b0;
        tick();
        chk("rst_inflight", valid_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        directed("post_rst", 23'h000010, 23'h000020, 23'h000030);

        // Throughput: both handshakes held high
        valid_i = 1'b1; ready_i = 1'b1; q_i = Q;
        for (int c = 0; c < 40; c++) begin
            a_i = 23'($urandom_range(Q - 1, 0));
            b_i = 23'($urandom_range(Q - 1, 0));
            tp_win = (c >= 5 && c < 35);
            tick();
        end
        tp_win = 1'b0;
        chk("throughput", tp_cnt, 30);

        // Random traffic, mostly with the Dilithium modulus, sometimes a per-operand random q
        for (int c = 0; c < 20000; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            rq = ($urandom_range(0, 7) == 0) ? 23'($urandom_range(23'h7FFFFF, 2)) : Q;
            q_i = rq;
            a_i = 23'($urandom_range(rq - 1, 0));
            b_i = 23'($urandom_range(rq - 1, 0));
            tick();
        end

        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (10) tick();
        chk("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
